// File: rtl/mdu_if.sv
// mdu_if: E/M/D-stage to multiply/divide unit bundle.
// master drives start/op/operands/flush/d_is_md; slave returns busy/stall_d/hi/lo.
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        d_is_md;
  logic        busy;
  logic        stall_d;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    output flush, d_is_md,
    input  busy, stall_d, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    input  flush, d_is_md,
    output busy, stall_d, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: mult/div sequencer owning HI/LO; ports clk, rst_n, md (mdu_if.slave).
// MDU_MADD_EN enables madd/maddu/msub/msubu (ops 7-10).
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave md
);

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] pend;
  logic        pend_wr;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic is_mul, is_div, is_mthi, is_mtlo;
  logic is_acc, acc_sub, sgn;
  logic take;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    is_acc  = 1'b0;
    acc_sub = 1'b0;
    sgn     = 1'b0;
    case (md.op)
      4'd1: begin is_mul = 1'b1; sgn = 1'b1; end
      4'd2: is_mul = 1'b1;
      4'd3: begin is_div = 1'b1; sgn = 1'b1; end
      4'd4: is_div = 1'b1;
      4'd5: is_mthi = 1'b1;
      4'd6: is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      4'd7: begin
        is_mul = 1'b1; is_acc = 1'b1; sgn = 1'b1;
      end
      4'd8: begin
        is_mul = 1'b1; is_acc = 1'b1;
      end
      4'd9: begin
        is_mul = 1'b1; is_acc = 1'b1;
        acc_sub = 1'b1; sgn = 1'b1;
      end
      4'd10: begin
        is_mul = 1'b1; is_acc = 1'b1;
        acc_sub = 1'b1;
      end
`else
      4'd7, 4'd8, 4'd9, 4'd10: ;
`endif
      default: ;
    endcase
  end

  assign take = md.start & ~md.flush
              & (state == IDLE);

  logic [63:0] a64, b64, prod, base;
  logic [63:0] mul_res;

  // Low 64 bits of a 64x64 product are right
  // for both extensions.
  assign a64 = sgn ? {{32{md.rs_val[31]}}, md.rs_val}
                   : {32'b0, md.rs_val};
  assign b64 = sgn ? {{32{md.rt_val[31]}}, md.rt_val}
                   : {32'b0, md.rt_val};
  assign prod = a64 * b64;
  assign base = {hi_q, lo_q};
  assign mul_res = !is_acc ? prod
                 : acc_sub ? base - prod
                 : base + prod;

  logic        neg_a, neg_b, div_ok;
  logic [31:0] ua, ub, dv, uq, ur, q, r;

  // Signed divide via magnitudes; the
  // 0x80000000 / -1 case falls out as
  // q = 0x80000000, r = 0.
  assign neg_a  = sgn & md.rs_val[31];
  assign neg_b  = sgn & md.rt_val[31];
  assign ua     = neg_a ? -md.rs_val : md.rs_val;
  assign ub     = neg_b ? -md.rt_val : md.rt_val;
  assign div_ok = (md.rt_val != 32'd0);
  assign dv     = div_ok ? ub : 32'd1;
  assign uq     = ua / dv;
  assign ur     = ua % dv;
  assign q      = (neg_a ^ neg_b) ? -uq : uq;
  assign r      = neg_a ? -ur : ur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pend    <= 64'd0;
      pend_wr <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            unique case (1'b1)
              is_mthi: hi_q <= md.rs_val;
              is_mtlo: lo_q <= md.rs_val;
              is_mul: begin
                pend    <= mul_res;
                pend_wr <= 1'b1;
                cnt     <= MC;
                state   <= RUN;
                busy_q  <= 1'b1;
              end
              is_div: begin
                pend    <= {r, q};
                pend_wr <= div_ok;
                cnt     <= DC;
                state   <= RUN;
                busy_q  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == 4'd1) begin
            if (pend_wr) begin
              hi_q <= pend[63:32];
              lo_q <= pend[31:0];
            end
            pend_wr <= 1'b0;
            cnt     <= 4'd0;
            state   <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.busy    = busy_q;
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;
  assign md.stall_d = md.d_is_md
                    & (busy_q | (md.start & ~md.flush));

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the 5-stage MIPS pipeline.
- Accepts MD-class instructions from the E stage and sequences multi-cycle mult/div operations.
- Owns the HI/LO architectural registers and produces the D-stage stall for any MD-class instruction while an operation is in flight.
- Exception flush from the M stage cancels a start that is issued in the same cycle.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family), legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu, legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is MD-class and valid this cycle
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; others treated as none
- rs_val  input  32  forwarded E-stage rs operand
- rt_val  input  32  forwarded E-stage rt operand
- flush  input  1  exception/eret taken in M; cancels a same-cycle start
- d_is_md  input  1  D-stage instruction is any MD-class op (including mfhi/mflo)
- busy  output  1  operation in flight
- stall_d  output  1  stall request to the hazard unit
- hi  output  32  HI register, read by mfhi
- lo  output  32  LO register, read by mflo

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, hi=0, lo=0, busy=0, pending result cleared.
- stall_d = d_is_md & (busy | (start & ~flush)), combinational.
- Accepted start: start & ~flush & state==IDLE & op!=none. A start while RUN is ignored; the hazard unit guarantees this cannot happen.
- FSM states: IDLE and RUN.
- IDLE, mthi/mtlo: hi or lo <= rs_val at the clock edge. Stays IDLE; busy stays 0.
- IDLE, mult/multu/div/divu/madd family:
  - Compute the 64-bit pending result from rs_val/rt_val at the accept edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN:
  - busy=1; counter decrements each cycle.
  - When counter==1, at that edge: commit pending to hi/lo, go to IDLE, counter 0.
  - Net timing: start at cycle T, busy high in T+1..T+N, new hi/lo visible from T+N+1, busy low in T+N+1.
- Arithmetic:
  - mult: signed 32x32->64, hi=upper, lo=lower.
  - multu: unsigned 32x32->64.
  - div: lo=signed quotient, hi=signed remainder; remainder sign follows dividend. 0x80000000/-1 gives lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero: still busy for DIV_CYCLES; hi/lo unchanged at commit.
- flush:
  - Affects only a same-cycle start; no state change.
  - flush during RUN does not abort: the in-flight op belongs to an older, committed instruction.
- Reset mid-RUN: the pending result is discarded and hi/lo return to 0 immediately.
- Counter width: 4 bits. MULT_CYCLES/DIV_CYCLES outside 1..15 are not supported.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 7-10 accepted with MULT_CYCLES latency.
  - madd: {hi,lo} + signed product.
  - maddu: {hi,lo} + unsigned product.
  - msub/msubu: {hi,lo} - product.
  - 64-bit arithmetic, wrap-around on overflow. The accumulator base is the {hi,lo} value at the accept edge.
- Not defined: ops 7-10 treated as none (no busy, no state change, no stall contribution beyond the start term).

Test Plan:
- Reset then mult rs=0xFFFFFFFE(-2), rt=3 at cycle T, MULT_CYCLES=5 -> busy high T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA from T+6.
- divu rs=100, rt=7 with d_is_md=1 (mflo in D) throughout -> stall_d high T..T+10, low at T+11; lo=14, hi=2 from T+11.
- div rs=0xFFFFFFF9(-7), rt=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); then div by rt=0 -> hi/lo unchanged after 10 busy cycles.
- mult issued with flush=1 same cycle -> busy never rises, hi/lo unchanged. Next: mthi rs=0x1234 with busy=0 -> hi=0x1234 next cycle, stall_d never asserted.
- mult in flight, rst_n pulled low at T+3 (between clock edges) -> busy=0, hi=lo=0 immediately; no commit after release.
- MDU_MADD_EN defined, hi=0, lo=0xFFFFFFFF, maddu rs=1, rt=1 -> hi=1, lo=0 after MULT_CYCLES. Macro undefined: same op -> busy stays 0, hi/lo unchanged.
